// File: rtl/fp_div_seq.sv
// Iterative restoring FP divider on field-separated operands.
// Ports: clk, rst_n, in_valid/in_ready + sign/exp/mantissa x,y; out_valid/out_ready + sign/exp/mantissa_out.
module fp_div_seq #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int EXP_WIDTH      = 8,
  parameter int APPROX_BITS    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sign_x,
  input  logic                      sign_y,
  input  logic [EXP_WIDTH-1:0]      exp_x,
  input  logic [EXP_WIDTH-1:0]      exp_y,
  input  logic [MANTISSA_WIDTH-1:0] mantissa_x,
  input  logic [MANTISSA_WIDTH-1:0] mantissa_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sign_out,
  output logic [EXP_WIDTH-1:0]      exp_out,
  output logic [MANTISSA_WIDTH-1:0] mantissa_out
);

  localparam int MW = MANTISSA_WIDTH;
  localparam int EW = EXP_WIDTH;
  localparam int N  = MW + 1 - APPROX_BITS;
  localparam int CW = $clog2(MW + 2);
  localparam logic [EW+1:0] BIAS = (EW+2)'(2**(EW-1) - 1);
  localparam logic [EW:0]   EMAX = (EW+1)'(2**EW - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PACK,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                 sign_r;
  logic signed [EW+1:0] exp_r;
  logic [MW+1:0]        rem_r;
  logic [MW:0]          div_r;
  logic [MW:0]          quo_r;
  logic [CW-1:0]        cnt_r;

  logic [MW:0]   x_m;
  logic [MW:0]   y_m;
  logic          lt;
  logic [EW+1:0] exp_nx;
  logic          ge;
  logic [MW+1:0] diff;
  logic [MW:0]   qs;
  logic          ovf;
  logic          unf;

  assign x_m = {1'b1, mantissa_x};
  assign y_m = {1'b1, mantissa_y};
  assign lt  = x_m < y_m;

  // Two's complement in EW+2 bits; range never wraps.
  assign exp_nx = {2'b00, exp_x} - {2'b00, exp_y} + BIAS
                - {{(EW+1){1'b0}}, lt};

  assign ge   = rem_r >= {1'b0, div_r};
  assign diff = ge ? rem_r - {1'b0, div_r} : rem_r;

  // Quotient MSB lands above the fraction field and drops off.
  assign qs = quo_r << APPROX_BITS;

  assign ovf = !exp_r[EW+1] && (exp_r[EW:0] >= EMAX);
  assign unf = exp_r[EW+1] || (exp_r == '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = DIV;
      DIV:  if (cnt_r == CW'(1)) state_nx = PACK;
      PACK: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r       <= 1'b0;
      exp_r        <= '0;
      rem_r        <= '0;
      div_r        <= '0;
      quo_r        <= '0;
      cnt_r        <= '0;
      sign_out     <= 1'b0;
      exp_out      <= '0;
      mantissa_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sign_r <= sign_x ^ sign_y;
          exp_r  <= exp_nx;
          rem_r  <= lt ? {x_m, 1'b0} : {1'b0, x_m};
          div_r  <= y_m;
          quo_r  <= '0;
          cnt_r  <= CW'(N);
        end
        DIV: begin
          rem_r <= {diff[MW:0], 1'b0};
          quo_r <= {quo_r[MW-1:0], ge};
          cnt_r <= cnt_r - CW'(1);
        end
        PACK: begin
          sign_out <= sign_r;
          unique case (1'b1)
            ovf: begin
              exp_out      <= {{(EW-1){1'b1}}, 1'b0};
              mantissa_out <= '1;
            end
            unf: begin
              exp_out      <= EW'(1);
              mantissa_out <= '0;
            end
            default: begin
              exp_out      <= exp_r[EW-1:0];
              mantissa_out <= qs[MW-1:0];
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
